keypad_encoder: RTL
===================

// Module: keypad_encoder
// PURPOSE
//   Scans a 4x4 matrix keypad and encodes one debounced key press into a 4-bit hex code.
//   Sits upstream of the hex-to-seven-segment display path; key_code feeds the display digits.
//   Drives rows active-low one at a time and reads active-low columns (external pull-ups).
//   Emits a one-cycle key_valid per press; ignores further keys while one is held.
// PARAMETERS
//   SCAN_DIV         1000   clk cycles each row is driven before its columns are sampled
//   DEBOUNCE_CYCLES  20000  consecutive stable cycles required to accept a press or a release
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   reset      in   1  asynchronous, active-high reset
//   col        in   4  raw keypad columns, active-low, asynchronous to clk
//   row        out  4  keypad row drive, active-low, exactly one bit low at all times
//   key_code   out  4  hex code of last accepted key; holds until the next accepted press
//   key_valid  out  1  one-cycle pulse when a new press is accepted
//   key_held   out  1  high while an accepted key is held (through release debounce)
// BEHAVIOUR
//   Reset: row=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, counters=0.
//     Reset takes effect immediately in any state; no pulse is generated by reset or its release.
//   Sync: col passes through a 2-flop synchronizer -> col_s; only col_s is used internally.
//   Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D.
//   States:
//   SCAN: dwell counter runs 0..SCAN_DIV-1 on the current row. At SCAN_DIV-1, sample col_s:
//     any bit low -> latch row index and lowest-index low column, clear counter, go DEBOUNCE
//     (row drive frozen). None low -> rotate row 1110->1101->1011->0111->1110, clear counter.
//   DEBOUNCE: row frozen. Latched column high in any cycle -> clear counter, advance to the
//     next row, go SCAN. Latched column low for DEBOUNCE_CYCLES consecutive cycles -> go HELD.
//     On that transition: key_code=map(row,col) and key_valid=1 in the same cycle; key_held=1.
//   HELD: row frozen. key_valid=0. Other columns and rows are ignored.
//     Latched column high -> clear counter, go RELEASE.
//   RELEASE: latched column low in any cycle -> back to HELD, no new key_valid.
//     High for DEBOUNCE_CYCLES consecutive cycles -> key_held=0, advance row, go SCAN.
//   Press latency: at most 2 sync + 4*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles after col settles.
//   key_valid never asserts on consecutive cycles. One pulse per accepted press.
//   Counters are sized $clog2(max(SCAN_DIV,DEBOUNCE_CYCLES)+1) bits and never wrap.
//   Multiple keys in the same row: lowest column index wins. A second key in another row is
//     not seen until the first is released. It is then found on a later scan and produces a new pulse.
//   key_code retains its value across releases and idle scanning.
// TESTING (bench params SCAN_DIV=4, DEBOUNCE_CYCLES=8; keypad model shorts row to col)
//   Reset -> row=1110, key_code=0, key_valid=0, key_held=0. Idle 100 cycles -> row cycles through
//     all four one-low values, every 4 cycles each, and key_valid stays 0.
//   Hold key '5' (r1,c1) 200 cycles -> exactly one key_valid pulse, key_code=4'h5, and key_held=1.
//     Release -> key_held=0 after 8 stable cycles, and key_code stays 5.
//   Sweep all 16 keys, one at a time -> 16 pulses with codes 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D.
//   Bounce: press '9' for 3 cycles only, then release -> no key_valid, and scanning resumes.
//     In HELD, open col 3 cycles then close -> no new pulse, and key_held stays 1.
//   Hold 'F', then also press '1', then release 'F' -> one pulse code F. After the release
//     debounce, a second pulse with code 1 follows.
//   Assert reset while in HELD ('A' held) -> outputs at reset values immediately. After deassert,
//     the still-held 'A' is re-detected and re-pulses once with key_code=A.

Source files
------------

// File: rtl/keypad_encoder.sv
// ---------------------------------------------------------------------------
// keypad_encoder
//   Scans a 4x4 matrix keypad and turns one debounced key press into a 4-bit
//   hex code for the downstream seven-segment display path. Rows are driven
//   active-low one at a time; columns are read active-low (external pull-ups).
//   One key is tracked at a time: while it is held, every other key is ignored.
//
// Parameters
//   SCAN_DIV         cycles each row is driven before its columns are sampled
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept press/release
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   col[3:0]   in   raw keypad columns, active-low, asynchronous to clk
//   row[3:0]   out  row drive, active-low, exactly one bit low at all times
//   key_code   out  hex code of the last accepted key (held until next press)
//   key_valid  out  one-cycle pulse when a new press is accepted
//   key_held   out  high while the accepted key is held, incl. release debounce
// ---------------------------------------------------------------------------
module keypad_encoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_COUNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      row_idx, row_idx_nx;
  logic [1:0]      col_idx, col_idx_nx;
  logic [3:0]      key_code_nx;
  logic            key_valid_nx;

  logic [3:0]      col_meta, col_s;
  logic            any_low;
  logic [1:0]      low_col;
  logic            col_open;

  // Key map indexed by {row, col}.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; idles at all-ones (no key) so reset cannot fake a press.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  // Lowest-index low column wins when several keys in the row are closed.
  always_comb begin
    any_low = 1'b0;
    low_col = 2'd0;
    if      (!col_s[0]) begin any_low = 1'b1; low_col = 2'd0; end
    else if (!col_s[1]) begin any_low = 1'b1; low_col = 2'd1; end
    else if (!col_s[2]) begin any_low = 1'b1; low_col = 2'd2; end
    else if (!col_s[3]) begin any_low = 1'b1; low_col = 2'd3; end
  end

  assign col_open = col_s[col_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cnt       <= '0;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      row_idx   <= row_idx_nx;
      col_idx   <= col_idx_nx;
      key_code  <= key_code_nx;
      key_valid <= key_valid_nx;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_nx     = state;
    cnt_nx       = cnt;
    row_idx_nx   = row_idx;
    col_idx_nx   = col_idx;
    key_code_nx  = key_code;
    key_valid_nx = 1'b0;

    case (state)
      SCAN: begin
        if (cnt == CW'(SCAN_DIV - 1)) begin
          cnt_nx = '0;
          if (any_low) begin
            col_idx_nx = low_col;
            state_nx   = DEBOUNCE;
          end else begin
            row_idx_nx = row_idx + 2'd1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      DEBOUNCE: begin
        if (col_open) begin
          // Bounce: give up on this row and continue the scan past it.
          cnt_nx     = '0;
          row_idx_nx = row_idx + 2'd1;
          state_nx   = SCAN;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_nx       = '0;
          state_nx     = HELD;
          key_code_nx  = key_map(row_idx, col_idx);
          key_valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      HELD: begin
        if (col_open) begin
          cnt_nx   = '0;
          state_nx = RELEASE;
        end
      end

      RELEASE: begin
        if (!col_open) begin
          // Release bounce: the same press continues, no new pulse.
          cnt_nx   = '0;
          state_nx = HELD;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_nx     = '0;
          row_idx_nx = row_idx + 2'd1;
          state_nx   = SCAN;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      default: begin
        cnt_nx   = '0;
        state_nx = SCAN;
      end
    endcase
  end

  assign row      = ~(4'b0001 << row_idx);
  assign key_held = (state == HELD) || (state == RELEASE);

endmodule
